// File: rtl/traffic_light_sequencer_pkg.sv
// Shared phase encodings and FSM constants for the traffic light sequencer
// and the downstream traffic light controller.
package traffic_light_sequencer_pkg;

    localparam logic [1:0] PHASE_ERROR  = 2'b00;
    localparam logic [1:0] PHASE_RED    = 2'b01;
    localparam logic [1:0] PHASE_YELLOW = 2'b10;
    localparam logic [1:0] PHASE_GREEN  = 2'b11;

    localparam logic [2:0] ST_HALT   = 3'd0;
    localparam logic [2:0] ST_RED    = 3'd1;
    localparam logic [2:0] ST_GREEN  = 3'd2;
    localparam logic [2:0] ST_YELLOW = 3'd3;
    localparam logic [2:0] ST_ERROR  = 3'd4;

    localparam logic SUB_ARM = 1'b0;
    localparam logic SUB_RUN = 1'b1;

    function automatic logic [1:0] phase_code(input logic [2:0] st);
        logic [1:0] code;
        case (st)
            ST_RED:    code = PHASE_RED;
            ST_GREEN:  code = PHASE_GREEN;
            ST_YELLOW: code = PHASE_YELLOW;
            default:   code = PHASE_ERROR;
        endcase
        return code;
    endfunction

    function automatic logic is_running(input logic [2:0] st);
        return (st == ST_RED) || (st == ST_GREEN) || (st == ST_YELLOW);
    endfunction

    function automatic logic [2:0] next_phase(input logic [2:0] st);
        logic [2:0] nxt;
        case (st)
            ST_RED:   nxt = ST_GREEN;
            ST_GREEN: nxt = ST_YELLOW;
            default:  nxt = ST_RED;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/traffic_light_sequencer_phase_watchdog.sv
// Counts consecutive ARM cycles with a zero countdown and pulses timeout
// on the last permitted cycle.
module phase_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic clear,
    input  logic count_en,
    output logic timeout
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] count;

    assign timeout = count_en && (count == CNT_W'(TIMEOUT - 1));

    // Any cycle that is not a continued zero-countdown ARM cycle restarts the count.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            count <= '0;
        end else if (clear || !count_en) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/traffic_light_sequencer.sv
// Phase sequencer driving the traffic light controller: RED -> GREEN -> YELLOW,
// with halt, fault/clear, ARM watchdog and pedestrian walk handling.
module traffic_light_sequencer
    import traffic_light_sequencer_pkg::*;
#(
    parameter int ARM_TIMEOUT = 16,
    parameter int CYCLE_W     = 8
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_run,
    input  logic               i_fault,
    input  logic               i_clear,
    input  logic [6:0]         i_value,
    input  logic               i_ped_req,
    output logic [1:0]         o_state,
    output logic               o_en,
    output logic               o_walk,
    output logic               o_ped_pending,
    output logic               o_error,
    output logic [CYCLE_W-1:0] o_cycle_count
);

    logic [2:0] fsm;
    logic [2:0] fsm_next;
    logic       sub;
    logic       sub_next;
    logic       wd_count_en;
    logic       wd_clear;
    logic       wd_timeout;
    logic       ped_seen;
    logic       entering_red;

    assign wd_count_en  = is_running(fsm) && (sub == SUB_ARM) && (i_value == 7'd0);
    assign wd_clear     = (fsm_next != fsm);
    assign ped_seen     = o_ped_pending || (i_ped_req && (fsm != ST_ERROR));
    assign entering_red = (fsm_next == ST_RED) && (fsm != ST_RED);

    phase_watchdog #(
        .TIMEOUT (ARM_TIMEOUT)
    ) u_watchdog (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .clear     (wd_clear),
        .count_en  (wd_count_en),
        .timeout   (wd_timeout)
    );

    // Branch order encodes priority: fault, halt request, watchdog, phase advance.
    always_comb begin
        fsm_next = fsm;
        sub_next = sub;
        case (fsm)
            ST_ERROR: begin
                if (i_clear && !i_fault) begin
                    fsm_next = ST_HALT;
                end
            end
            ST_HALT: begin
                if (i_fault) begin
                    fsm_next = ST_ERROR;
                end else if (i_run) begin
                    fsm_next = ST_RED;
                end
            end
            default: begin
                if (i_fault) begin
                    fsm_next = ST_ERROR;
                end else if (!i_run) begin
                    fsm_next = ST_HALT;
                end else if (wd_timeout) begin
                    fsm_next = ST_ERROR;
                end else if (sub == SUB_ARM) begin
                    if (i_value != 7'd0) begin
                        sub_next = SUB_RUN;
                    end
                end else if (i_value == 7'd0) begin
                    fsm_next = next_phase(fsm);
                end
            end
        endcase
        if (fsm_next != fsm) begin
            sub_next = SUB_ARM;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            fsm           <= ST_HALT;
            sub           <= SUB_ARM;
            o_state       <= PHASE_ERROR;
            o_en          <= 1'b0;
            o_error       <= 1'b0;
            o_walk        <= 1'b0;
            o_ped_pending <= 1'b0;
            o_cycle_count <= '0;
        end else begin
            fsm     <= fsm_next;
            sub     <= sub_next;
            o_state <= phase_code(fsm_next);
            o_en    <= is_running(fsm_next);
            o_error <= (fsm_next == ST_ERROR);
            if ((fsm == ST_YELLOW) && (fsm_next == ST_RED)) begin
                o_cycle_count <= o_cycle_count + CYCLE_W'(1);
            end
            // A request arriving on the RED-entry cycle is served by that RED.
            if (entering_red && ped_seen) begin
                o_walk        <= 1'b1;
                o_ped_pending <= 1'b0;
            end else begin
                o_ped_pending <= ped_seen;
                if (fsm_next != ST_RED) begin
                    o_walk <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Scoreboard bench: a phase-level reference model predicts every cycle's outputs,
// a monitor compares them against the sequencer after each rising edge.
module tb_traffic_light_sequencer;

    localparam int ARM_TIMEOUT = 16;
    localparam int CYCLE_W     = 8;

    localparam int M_HALT   = 0;
    localparam int M_RED    = 1;
    localparam int M_GREEN  = 2;
    localparam int M_YELLOW = 3;
    localparam int M_ERROR  = 4;

    typedef struct {
        logic [1:0]         st;
        logic               en;
        logic               walk;
        logic               pend;
        logic               err;
        logic [CYCLE_W-1:0] cnt;
    } expect_t;

    logic               i_clk = 1'b0;
    logic               i_reset_n = 1'b0;
    logic               i_run = 1'b0;
    logic               i_fault = 1'b0;
    logic               i_clear = 1'b0;
    logic [6:0]         i_value = 7'd0;
    logic               i_ped_req = 1'b0;
    logic [1:0]         o_state;
    logic               o_en;
    logic               o_walk;
    logic               o_ped_pending;
    logic               o_error;
    logic [CYCLE_W-1:0] o_cycle_count;

    expect_t exp_q[$];
    int total = 0;
    int bad   = 0;

    int m_phase = M_HALT;
    bit m_waiting = 1'b1;
    int m_wait = 0;
    bit m_walk = 1'b0;
    bit m_pend = 1'b0;
    int m_cycles = 0;

    int ctl_prev = -1;
    int ctl_delay = 0;
    int ctl_val = 0;
    int forced_delay = -1;
    int delay_pct = 0;

    traffic_light_sequencer #(
        .ARM_TIMEOUT (ARM_TIMEOUT),
        .CYCLE_W     (CYCLE_W)
    ) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_run         (i_run),
        .i_fault       (i_fault),
        .i_clear       (i_clear),
        .i_value       (i_value),
        .i_ped_req     (i_ped_req),
        .o_state       (o_state),
        .o_en          (o_en),
        .o_walk        (o_walk),
        .o_ped_pending (o_ped_pending),
        .o_error       (o_error),
        .o_cycle_count (o_cycle_count)
    );

    always #5 i_clk = ~i_clk;

    function automatic int load_value(input int ph);
        if (ph == M_RED) return 10;
        if (ph == M_GREEN) return 7;
        return 3;
    endfunction

    function automatic bit running(input int ph);
        return (ph >= M_RED) && (ph <= M_YELLOW);
    endfunction

    // Phase-level behaviour: one call is one clock edge.
    task automatic model_step(input bit rst, input bit run, input bit fault,
                              input bit clear, input bit ped, input int value);
        int nxt;
        if (!rst) begin
            m_phase = M_HALT; m_waiting = 1'b1; m_wait = 0;
            m_walk = 1'b0; m_pend = 1'b0; m_cycles = 0;
            return;
        end
        nxt = m_phase;
        if (m_phase == M_ERROR) begin
            if (clear && !fault) nxt = M_HALT;
        end else if (fault) begin
            nxt = M_ERROR;
        end else if (m_phase == M_HALT) begin
            if (run) nxt = M_RED;
        end else if (!run) begin
            nxt = M_HALT;
        end else if (m_waiting) begin
            if (value != 0) m_waiting = 1'b0;
            else if (m_wait == ARM_TIMEOUT - 1) nxt = M_ERROR;
            else m_wait++;
        end else if (value == 0) begin
            nxt = (m_phase % 3) + 1;
        end
        if (ped && m_phase != M_ERROR) m_pend = 1'b1;
        if (nxt == M_RED && m_phase != M_RED) begin
            if (m_pend) begin
                m_walk = 1'b1;
                m_pend = 1'b0;
            end
        end else if (nxt != M_RED) begin
            m_walk = 1'b0;
        end
        if (m_phase == M_YELLOW && nxt == M_RED) m_cycles = (m_cycles + 1) % (1 << CYCLE_W);
        if (nxt != m_phase) begin
            m_waiting = 1'b1;
            m_wait = 0;
        end
        m_phase = nxt;
    endtask

    function automatic expect_t model_outputs();
        expect_t e;
        int codes[5] = '{0, 1, 3, 2, 0};
        e.st   = 2'(codes[m_phase]);
        e.en   = running(m_phase);
        e.walk = m_walk;
        e.pend = m_pend;
        e.err  = (m_phase == M_ERROR);
        e.cnt  = CYCLE_W'(m_cycles);
        return e;
    endfunction

    task automatic applyStimulus(input bit rst, input bit run, input bit fault,
                                 input bit clear, input bit ped);
        int value;
        @(negedge i_clk);
        if (running(m_phase)) begin
            if (m_phase != ctl_prev) begin
                ctl_val = load_value(m_phase);
                if (forced_delay >= 0 && m_phase == M_GREEN) begin
                    ctl_delay = forced_delay;
                    forced_delay = -1;
                end else if (int'($urandom_range(99)) < delay_pct) begin
                    ctl_delay = int'($urandom_range(ARM_TIMEOUT + 1));
                end else begin
                    ctl_delay = 0;
                end
            end
            value = (ctl_delay > 0) ? 0 : ctl_val;
            if (ctl_delay > 0) ctl_delay--;
            else if (ctl_val > 0) ctl_val--;
        end else begin
            value = int'($urandom_range(127));
        end
        ctl_prev  = m_phase;
        i_reset_n = rst;
        i_run     = run;
        i_fault   = fault;
        i_clear   = clear;
        i_ped_req = ped;
        i_value   = 7'(value);
        model_step(rst, run, fault, clear, ped, value);
        exp_q.push_back(model_outputs());
    endtask

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic checkOutput(input expect_t e);
        checkField("o_state", 32'(o_state), 32'(e.st));
        checkField("o_en", 32'(o_en), 32'(e.en));
        checkField("o_walk", 32'(o_walk), 32'(e.walk));
        checkField("o_ped_pending", 32'(o_ped_pending), 32'(e.pend));
        checkField("o_error", 32'(o_error), 32'(e.err));
        checkField("o_cycle_count", 32'(o_cycle_count), 32'(e.cnt));
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_phase(input int ph, input int budget);
        for (int i = 0; i < budget && m_phase != ph; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        if (m_phase != ph) begin
            total++;
            bad++;
            $display("[TB] FAIL wait_phase: model phase %0d, wanted %0d", m_phase, ph);
        end
    endtask

    always @(posedge i_clk) begin
        expect_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checkOutput(e);
        end
    end

    initial begin
        $display("[TB] reset and idle");
        repeat (3) applyStimulus(1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'($urandom));
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] basic sequencing");
        run_cycles(80);

        $display("[TB] watchdog");
        forced_delay = 16;
        wait_phase(M_GREEN, 100);
        run_cycles(20);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        forced_delay = 15;
        wait_phase(M_GREEN, 100);
        run_cycles(30);

        $display("[TB] pedestrian, fault and clear");
        wait_phase(M_GREEN, 100);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        wait_phase(M_RED, 100);
        run_cycles(3);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        run_cycles(2);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        run_cycles(5);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        run_cycles(5);

        $display("[TB] halt mid-yellow and reset mid-phase");
        wait_phase(M_YELLOW, 100);
        run_cycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        run_cycles(4);
        wait_phase(M_GREEN, 100);
        run_cycles(3);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] cycle counter wrap");
        for (int c = 0; c < 256; c++) begin
            wait_phase(M_YELLOW, 100);
            wait_phase(M_RED, 100);
        end
        @(posedge i_clk);
        #2;
        checkField("wrap_count", 32'(o_cycle_count), 32'd0);

        $display("[TB] randomized traffic");
        delay_pct = 10;
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(1'($urandom_range(499) != 0), 1'($urandom_range(49) != 0),
                          1'($urandom_range(63) == 0), 1'($urandom_range(7) == 0),
                          1'($urandom_range(9) == 0));
        end

        repeat (2) @(posedge i_clk);
        #2;
        checkField("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/traffic_light_sequencer.md
Name: traffic_light_sequencer

Overview:
Phase sequencer that sits directly upstream of the traffic light controller. It drives the controller's 2-bit state select and enable, and watches the controller's countdown value to decide when each phase has expired. It cycles RED -> GREEN -> YELLOW -> RED, and it also provides:
- a pedestrian-walk request latch,
- a fault/halt path that puts the controller into its flashing-yellow mode,
- a watchdog that catches a countdown that never loads.

Parameters:
ARM_TIMEOUT, 16, clock cycles allowed after phase entry for i_value to become non-zero before declaring a fault
CYCLE_W, 8, width of the completed-cycle counter

Ports:
i_clk  input  1  system clock; all logic on rising edge
i_reset_n  input  1  synchronous, active-low reset
i_run  input  1  1 = sequence normally; 0 = halt (controller disabled)
i_fault  input  1  external fault; forces ERROR
i_clear  input  1  single-cycle pulse; leaves ERROR
i_value  input  7  countdown value returned by the controller
i_ped_req  input  1  single-cycle pedestrian button pulse
o_state  output  2  phase select to controller: 00 error, 01 red, 10 yellow, 11 green
o_en  output  1  controller enable
o_walk  output  1  walk lamp; high during a served RED phase
o_ped_pending  output  1  pedestrian request latched but not yet served
o_error  output  1  high while in ERROR
o_cycle_count  output  CYCLE_W  count of completed RED->GREEN->YELLOW cycles; wraps

Behaviour:
- Clock and reset: one clock, i_clk. i_reset_n is synchronous and active-low.
- Values while i_reset_n=0 (same values on the first rising edge after release):
  - FSM = HALT, phase sub-state = ARM, watchdog = 0
  - o_state=00, o_en=0, o_walk=0, o_ped_pending=0, o_error=0, o_cycle_count=0
- FSM states and their outputs:
  - HALT: o_state=00, o_en=0.
  - RED: o_state=01, o_en=1.
  - GREEN: o_state=11, o_en=1.
  - YELLOW: o_state=10, o_en=1.
  - ERROR: o_state=00, o_en=0, o_error=1.
  - All outputs are registered.
- Phase sub-state inside RED, GREEN and YELLOW:
  - On entry the sub-state is ARM and the watchdog is 0.
  - ARM: if i_value != 0, move to RUN. Otherwise increment the watchdog. When the watchdog reaches ARM_TIMEOUT-1 with i_value still 0, go to ERROR on the next edge.
  - RUN: when i_value == 0, advance to the next phase on the next edge, entering it in ARM.
- Phase order is RED -> GREEN -> YELLOW -> RED. o_cycle_count increments on the YELLOW->RED transition only.
- HALT exit: HALT -> RED when i_run=1 and i_fault=0.
- Halt from a running phase: i_run=0 in any running phase -> HALT on the next edge. o_walk is cleared. o_ped_pending is retained.
- Fault: i_fault=1 in any state except ERROR -> ERROR on the next edge. It overrides every other transition and clears o_walk.
- ERROR exit: ERROR -> HALT only when i_clear=1 and i_fault=0 in the same cycle. i_clear together with i_fault=1 is ignored.
- Priority, highest first: reset, i_fault, i_run=0, watchdog timeout, phase advance.
- Pedestrian requests:
  - An i_ped_req pulse sets o_ped_pending in any state except ERROR. In ERROR, requests are dropped.
  - On a transition into RED, if o_ped_pending=1 (including a request arriving in that same cycle): o_walk<=1 and o_ped_pending<=0.
  - A request during a served RED sets o_ped_pending for the next RED.
  - o_walk clears on leaving RED.
- o_cycle_count wraps from 2^CYCLE_W-1 to 0 with no flag.
- The value of i_value is ignored in HALT and ERROR.

Decomposition:
- Shared package: phase encodings (ERROR 2'b00, RED 2'b01, YELLOW 2'b10, GREEN 2'b11), FSM state enum, ARM/RUN sub-state constants. The traffic light controller uses the same encoding constants.
- One sub-module: phase_watchdog, which holds the ARM-timeout counter. Inputs: clear-on-phase-entry, count-enable. Output: timeout pulse.

Test Plan:
- Basic sequencing: reset, then i_run=1; model returns i_value 10..0 for RED, 7..0 for GREEN, 3..0 for YELLOW -> o_state 01 -> 11 -> 10 -> 01 with o_en=1 throughout; o_cycle_count=1 after the first YELLOW->RED.
- Watchdog: enter GREEN and hold i_value=0 -> ERROR on the edge after 16 ARM cycles, with o_state=00, o_en=0, o_error=1. A non-zero i_value on cycle 15 instead -> RUN, no error.
- Fault and clear: i_fault pulse mid-RED -> ERROR next edge and o_walk=0. i_clear with i_fault=1 -> stays in ERROR. i_clear with i_fault=0 -> HALT, then RED if i_run=1.
- Pedestrian: i_ped_req during GREEN -> o_ped_pending=1. On entry to RED, o_walk=1 and pending=0. A second request during that RED -> pending=1 and o_walk stays 1 until RED exits. A request while in ERROR -> no effect.
- Run/reset interaction: i_run=0 mid-YELLOW -> HALT next edge and o_cycle_count unchanged. i_reset_n=0 mid-phase -> all outputs at reset values on that edge.
- Wrap-around: 256 full cycles -> o_cycle_count returns to 0.
